tour_move_sequencer: RTL
========================

Name: tour_move_sequencer

Overview:
Sequences a precomputed knight's tour into the 16-bit command stream consumed by the command processor. It fetches each one-hot knight move by index and splits it into two legs: a vertical leg (N/S), then a horizontal leg (E/W). Each leg is issued as one command, and the block waits for the processor to accept it and for the move-complete pulse. It sits between the tour solver's move storage and the command-source mux in front of cmd_proc; tour_active drives that mux select.

Parameters:
NUM_MOVES, 24, number of moves in the tour (1..32); 5x5 board = 24.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_tour  input  1  pulse; begin sequencing from move index 0
move  input  8  one-hot knight move at mv_indx (valid combinationally)
clr_cmd_rdy  input  1  processor accepted current cmd
send_resp  input  1  pulse; processor finished executing current move command
mv_indx  output  5  index of move being executed
cmd  output  16  command word: [15:12] opcode, [11:4] heading, [3:0] squares
cmd_rdy  output  1  cmd valid, held until clr_cmd_rdy
tour_active  output  1  high from start accept to completion; selects sequencer as command source
tour_done  output  1  one-cycle pulse at normal completion
err  output  1  sticky: illegal (non-one-hot) move fetched; cleared by next accepted start_tour

Behaviour:
- Reset (async, any state): state=IDLE, mv_indx=0, cmd=16'h0000, cmd_rdy=0, tour_active=0, tour_done=0, err=0.
- Opcodes: 4'h4 = move, 4'h5 = move with fanfare. The vertical leg uses 4'h4; the horizontal leg uses 4'h5.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit: dx,dy): 0:-1,+2  1:+1,+2  2:-2,+1  3:-2,-1  4:-1,-2  5:+1,-2  6:+2,-1  7:+2,+1.
- Vertical leg: heading N if dy>0, else S; squares=|dy|.
- Horizontal leg: heading E if dx>0, else W; squares=|dx|.
- States: IDLE, FETCH, ISSUE_V, WAIT_V, ISSUE_H, WAIT_H, FINISH.
- IDLE: on start_tour -> FETCH. Set mv_indx=0, tour_active=1, err=0. start_tour is ignored in all other states.
- FETCH: sample move.
  - Not exactly one-hot: err=1, tour_active=0 -> IDLE. No tour_done; no cmd_rdy.
  - Else latch decoded dx/dy and go to ISSUE_V.
- ISSUE_V: load cmd={4'h4, vert heading, |dy|}, cmd_rdy=1 (both registered, visible next cycle) -> WAIT_V.
- WAIT_V:
  - clr_cmd_rdy drops cmd_rdy at the next edge.
  - send_resp is honoured only after cmd_rdy has been cleared; a send_resp seen while cmd_rdy=1 is ignored.
  - On honoured send_resp -> ISSUE_H.
- ISSUE_H / WAIT_H: same rules, with cmd={4'h5, horiz heading, |dx|}.
- On honoured send_resp in WAIT_H:
  - If mv_indx==NUM_MOVES-1 -> FINISH.
  - Else mv_indx+1 -> FETCH.
- FINISH: tour_done=1 for one cycle, tour_active=0 -> IDLE. mv_indx holds its last value until the next start.
- Simultaneous clr_cmd_rdy and send_resp in the same cycle: clear cmd_rdy; the send_resp is ignored.
- cmd holds its value between issues; it is not cleared on acceptance.
- Latency: start_tour to first cmd_rdy high = 3 clocks (IDLE->FETCH->ISSUE_V->visible). Honoured send_resp in WAIT_V to next cmd_rdy = 2 clocks.

Test Plan:
- NUM_MOVES=1, move=8'h02, pulse start_tour, then ack each command (clr_cmd_rdy, then send_resp 5 clk later) -> cmd=16'h4002 then 16'h5BF1; tour_done pulses once; tour_active falls with it; err=0.
- move=8'h10 -> cmds 16'h47F2, 16'h53F1.
- move=8'h40 -> cmds 16'h47F1, 16'h5BF2.
- NUM_MOVES=3, moves 8'h80, 8'h08, 8'h01 -> six commands in order: 4001,5BF2,47F1,53F2,4002,53F1. mv_indx steps 0,1,2. One tour_done pulse.
- move=8'h03 on fetch -> err=1, cmd_rdy never asserts, tour_active=0, no tour_done. A new start_tour with a legal move clears err.
- send_resp asserted while cmd_rdy=1 -> state unchanged and no new cmd. Deassert rst_n in WAIT_H -> all outputs return to reset values immediately. A start_tour during an active tour -> ignored, mv_indx unchanged.

Source files
------------

// File: rtl/tour_move_sequencer.sv
// tour_move_sequencer: walks a stored knight's tour and emits one vertical leg
// command and one horizontal leg command per move, handshaking each with the
// command processor (cmd_rdy/clr_cmd_rdy, then send_resp).
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        tour_active,
  output logic        tour_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE_V = 3'd2,
    WAIT_V  = 3'd3,
    ISSUE_H = 3'd4,
    WAIT_H  = 3'd5,
    FINISH  = 3'd6
  } state_e;

  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;
  localparam logic [7:0] HDG_N      = 8'h00;
  localparam logic [7:0] HDG_W      = 8'h3F;
  localparam logic [7:0] HDG_S      = 8'h7F;
  localparam logic [7:0] HDG_E      = 8'hBF;
  localparam logic [4:0] LAST_IDX   = 5'(NUM_MOVES - 1);

  // True when exactly one bit of the move code is set.
  function automatic logic is_one_hot(input logic [7:0] v);
    logic [7:0] v_minus_one;
    v_minus_one = v - 8'd1;
    return (v != 8'h00) && ((v & v_minus_one) == 8'h00);
  endfunction

  // Leg split of a one-hot move: {north, |dy|, east, |dx|}.
  // North/east flags give the sign of dy/dx; magnitudes are 1 or 2.
  function automatic logic [5:0] decode_move(input logic [7:0] v);
    logic [5:0] leg;
    case (v)
      8'h01:   leg = {1'b1, 2'd2, 1'b0, 2'd1}; // dx -1, dy +2
      8'h02:   leg = {1'b1, 2'd2, 1'b1, 2'd1}; // dx +1, dy +2
      8'h04:   leg = {1'b1, 2'd1, 1'b0, 2'd2}; // dx -2, dy +1
      8'h08:   leg = {1'b0, 2'd1, 1'b0, 2'd2}; // dx -2, dy -1
      8'h10:   leg = {1'b0, 2'd2, 1'b0, 2'd1}; // dx -1, dy -2
      8'h20:   leg = {1'b0, 2'd2, 1'b1, 2'd1}; // dx +1, dy -2
      8'h40:   leg = {1'b0, 2'd1, 1'b1, 2'd2}; // dx +2, dy -1
      8'h80:   leg = {1'b1, 2'd1, 1'b1, 2'd2}; // dx +2, dy +1
      default: leg = 6'b00_0000;
    endcase
    return leg;
  endfunction

  state_e      state_q;
  logic [4:0]  mv_indx_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        tour_active_q;
  logic        tour_done_q;
  logic        err_q;
  logic [5:0]  leg_q;

  // Tour sequencing FSM; every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mv_indx_q     <= 5'd0;
      cmd_q         <= 16'h0000;
      cmd_rdy_q     <= 1'b0;
      tour_active_q <= 1'b0;
      tour_done_q   <= 1'b0;
      err_q         <= 1'b0;
      leg_q         <= 6'b00_0000;
    end else begin
      tour_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_tour) begin
            state_q       <= FETCH;
            mv_indx_q     <= 5'd0;
            tour_active_q <= 1'b1;
            err_q         <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          if (!is_one_hot(move)) begin
            err_q         <= 1'b1;
            tour_active_q <= 1'b0;
            state_q       <= IDLE;
          end else begin
            leg_q   <= decode_move(move);
            state_q <= ISSUE_V;
          end
        end
        ISSUE_V: begin
          cmd_q     <= {OP_MOVE, (leg_q[5] ? HDG_N : HDG_S), 2'b00, leg_q[4:3]};
          cmd_rdy_q <= 1'b1;
          state_q   <= WAIT_V;
        end
        WAIT_V: begin
          // A completion pulse only counts once the command has been taken.
          if (cmd_rdy_q) begin
            if (clr_cmd_rdy) begin
              cmd_rdy_q <= 1'b0;
            end else begin
              cmd_rdy_q <= 1'b1;
            end
          end else if (send_resp) begin
            state_q <= ISSUE_H;
          end else begin
            state_q <= WAIT_V;
          end
        end
        ISSUE_H: begin
          cmd_q     <= {OP_FANFARE, (leg_q[2] ? HDG_E : HDG_W), 2'b00, leg_q[1:0]};
          cmd_rdy_q <= 1'b1;
          state_q   <= WAIT_H;
        end
        WAIT_H: begin
          if (cmd_rdy_q) begin
            if (clr_cmd_rdy) begin
              cmd_rdy_q <= 1'b0;
            end else begin
              cmd_rdy_q <= 1'b1;
            end
          end else if (send_resp) begin
            if (mv_indx_q == LAST_IDX) begin
              state_q <= FINISH;
            end else begin
              mv_indx_q <= mv_indx_q + 5'd1;
              state_q   <= FETCH;
            end
          end else begin
            state_q <= WAIT_H;
          end
        end
        FINISH: begin
          tour_done_q   <= 1'b1;
          tour_active_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          state_q       <= IDLE;
          cmd_rdy_q     <= 1'b0;
          tour_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign mv_indx     = mv_indx_q;
  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign tour_active = tour_active_q;
  assign tour_done   = tour_done_q;
  assign err         = err_q;

endmodule
